sr_cmd_gen: RTL and testbench

- Upstream command stage for the SR flip-flop.
- Takes two asynchronous raw request lines (set, reset) from buttons or a slow domain, then synchronizes and debounces each one.
- Converts each debounced rising edge into a single-cycle s or r pulse.
- Guarantees s and r are never high together and enforces a minimum gap between pulses, so the 2'b11 (q=x) code never reaches the flip-flop.

---
 rtl/sr_cmd_gen_if.sv | 40 ++++
 rtl/sr_cmd_gen.sv | 142 ++++++++++++++
 tb/tb_sr_cmd_gen.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/sr_cmd_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : sr_cmd_gen_if
//  Description : Request/command bundle between the raw request sources and
//                the SR command generator.
//                  set_raw, reset_raw : raw asynchronous requests (may bounce)
//                  s, r               : one-cycle command pulses to the SR ff
//                  conflict           : set request dropped in favour of reset
//                  busy               : generator is holding off or has work
//                master : drives raw requests, observes the commands
//                slave  : the command generator
//  Revision    : 1.0 - initial release
// ============================================================================
interface sr_cmd_gen_if;
    logic set_raw;
    logic reset_raw;
    logic s;
    logic r;
    logic conflict;
    logic busy;

    modport master (
        output set_raw,
        output reset_raw,
        input  s,
        input  r,
        input  conflict,
        input  busy
    );

    modport slave (
        input  set_raw,
        input  reset_raw,
        output s,
        output r,
        output conflict,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/sr_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sr_cmd_gen
//  Description : Upstream command stage for an SR flip-flop. Each raw request
//                line is synchronised (2 flops) and debounced; a debounced
//                rising edge raises a pending bit, and a small arbiter turns
//                pending bits into single-cycle s / r pulses, never both at
//                once, with a forced idle gap after every pulse.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - sr_cmd_gen_if.slave (set_raw, reset_raw in;
//                       s, r, conflict, busy out)
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_cmd_gen #(
    parameter int DB_CNT = 4,
    parameter int CNT_W  = 8,
    parameter int HOLD   = 2
) (
    input  logic            clk,
    input  logic            rst,
    sr_cmd_gen_if.slave     bus
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DB_CNT - 1);
    localparam int               c_HOLD_W   = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_END = c_HOLD_W'(HOLD);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        HOLDOFF = 1'b1
    } state_t;

    // Channel 0 = set, channel 1 = reset
    logic [1:0] w_raw;
    logic [1:0] w_rise;

    assign w_raw = {bus.reset_raw, bus.set_raw};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_ch
            logic             r_sync1;
            logic             r_sync2;
            logic             r_stable;
            logic [CNT_W-1:0] r_cnt;

            // The stable value flips on the edge where the counter has seen
            // DB_CNT consecutive differing samples; only a 0->1 flip is an event.
            assign w_rise[g] = (r_sync2 != r_stable) && (r_cnt == c_CNT_LAST) && r_sync2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1  <= 1'b0;
                    r_sync2  <= 1'b0;
                    r_stable <= 1'b0;
                    r_cnt    <= '0;
                end else begin
                    r_sync1 <= w_raw[g];
                    r_sync2 <= r_sync1;
                    if (r_sync2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_stable <= r_sync2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    state_t              r_state;
    logic [c_HOLD_W-1:0] r_hold;
    logic                r_pend_s;
    logic                r_pend_r;
    logic                r_s;
    logic                r_r;
    logic                r_conflict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hold     <= '0;
            r_pend_s   <= 1'b0;
            r_pend_r   <= 1'b0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_conflict <= 1'b0;
            // New events accumulate; a channel already pending absorbs them.
            // A channel being serviced this edge is cleared below, so an
            // event landing on that same edge merges into the one issued.
            r_pend_s   <= r_pend_s | w_rise[0];
            r_pend_r   <= r_pend_r | w_rise[1];

            case (r_state)
                IDLE: begin
                    if (r_pend_r) begin
                        // Reset wins; a simultaneous set is dropped and flagged.
                        r_r        <= 1'b1;
                        r_conflict <= r_pend_s;
                        r_pend_r   <= 1'b0;
                        if (r_pend_s) begin
                            r_pend_s <= 1'b0;
                        end
                        r_hold     <= '0;
                        r_state    <= HOLDOFF;
                    end else if (r_pend_s) begin
                        r_s      <= 1'b1;
                        r_pend_s <= 1'b0;
                        r_hold   <= '0;
                        r_state  <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    // Leaving on hold==HOLD keeps pulse rising edges at least
                    // HOLD+2 cycles apart.
                    if (r_hold == c_HOLD_END) begin
                        r_hold  <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_hold <= r_hold + c_HOLD_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.s        = r_s;
    assign bus.r        = r_r;
    assign bus.conflict = r_conflict;
    assign bus.busy     = (r_state != IDLE) | r_pend_s | r_pend_r;

endmodule
`default_nettype wire

// File: tb/tb_sr_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_cmd_gen
//  Description : Self-checking bench for sr_cmd_gen. A cycle-level reference
//                model pushes the expected {s, r, conflict, busy} for every
//                clock edge into a queue; a monitor pops and compares on the
//                falling edge. Directed scenarios followed by random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_cmd_gen;

    localparam int DB_CNT = 4;
    localparam int CNT_W  = 8;
    localparam int HOLD   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sr_cmd_gen_if bus ();

    sr_cmd_gen #(
        .DB_CNT (DB_CNT),
        .CNT_W  (CNT_W),
        .HOLD   (HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic s;
        logic r;
        logic conflict;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // ------------------------------------------------------------------
    // Reference model. hist[k] holds the raw level sampled k+1 edges ago.
    // A channel's stable level flips once the DB_CNT samples that have
    // reached the synchroniser output all disagree with it. Pulses are
    // granted from a pending set whenever the edge count has reached
    // free_at, which is pushed HOLD+2 edges past every grant.
    // ------------------------------------------------------------------
    logic [DB_CNT:0] m_hist_s, m_hist_r;
    logic            m_stab_s, m_stab_r;
    logic            m_pend_s, m_pend_r;
    int              cyc     = 0;
    int              free_at = 0;

    always @(posedge clk) begin : model
        exp_t e;
        logic ev_s, ev_r, clr_s, clr_r;
        cyc = cyc + 1;
        e   = '0;
        if (rst) begin
            m_hist_s = '0;
            m_hist_r = '0;
            m_stab_s = 1'b0;
            m_stab_r = 1'b0;
            m_pend_s = 1'b0;
            m_pend_r = 1'b0;
            free_at  = 0;
        end else begin
            ev_s = 1'b0;
            ev_r = 1'b0;
            if (m_hist_s[DB_CNT:1] == {DB_CNT{~m_stab_s}}) begin
                ev_s     = ~m_stab_s;
                m_stab_s = ~m_stab_s;
            end
            if (m_hist_r[DB_CNT:1] == {DB_CNT{~m_stab_r}}) begin
                ev_r     = ~m_stab_r;
                m_stab_r = ~m_stab_r;
            end
            clr_s = 1'b0;
            clr_r = 1'b0;
            if (cyc >= free_at && (m_pend_s || m_pend_r)) begin
                if (m_pend_r) begin
                    e.r        = 1'b1;
                    e.conflict = m_pend_s;
                    clr_r      = 1'b1;
                    clr_s      = m_pend_s;
                end else begin
                    e.s   = 1'b1;
                    clr_s = 1'b1;
                end
                free_at = cyc + HOLD + 2;
            end
            m_pend_s = clr_s ? 1'b0 : (m_pend_s | ev_s);
            m_pend_r = clr_r ? 1'b0 : (m_pend_r | ev_r);
            e.busy   = m_pend_s | m_pend_r | (cyc < free_at - 1);
            m_hist_s = {m_hist_s[DB_CNT-1:0], bus.set_raw};
            m_hist_r = {m_hist_r[DB_CNT-1:0], bus.reset_raw};
        end
        exp_q.push_back(e);
    end

    // ------------------------------------------------------------------
    // Monitor: compares DUT outputs against the queued expectation.
    // ------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        exp_t e;
        exp_t got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {bus.s, bus.r, bus.conflict, bus.busy};
            checks = checks + 1;
            if (got !== e) begin
                errors = errors + 1;
                $display("FAIL outputs @%0t: got s=%b r=%b conflict=%b busy=%b, expected s=%b r=%b conflict=%b busy=%b",
                         $time, got.s, got.r, got.conflict, got.busy,
                         e.s, e.r, e.conflict, e.busy);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 time units after the falling edge.
    // ------------------------------------------------------------------
    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic drive(input logic sv, input logic rv, input int n);
        bus.set_raw   = sv;
        bus.reset_raw = rv;
        repeat (n) step();
    endtask

    // Asserting reset must clear every output (busy included) at once.
    task automatic assert_rst_and_check();
        rst = 1'b1;
        #1;
        checks = checks + 1;
        if ({bus.s, bus.r, bus.conflict, bus.busy} !== 4'b0000) begin
            errors = errors + 1;
            $display("FAIL rst_immediate @%0t: got s,r,conflict,busy=%b, expected 0000",
                     $time, {bus.s, bus.r, bus.conflict, bus.busy});
        end
    endtask

    initial begin
        int   len_s, len_r;
        logic vs, vr;

        bus.set_raw   = 1'b0;
        bus.reset_raw = 1'b0;
        rst           = 1'b1;

        // Reset held while raw inputs toggle
        for (int i = 0; i < 6; i++) begin
            bus.set_raw   = 1'($urandom_range(0, 1));
            bus.reset_raw = 1'($urandom_range(0, 1));
            step();
        end
        bus.set_raw   = 1'b0;
        bus.reset_raw = 1'b0;
        rst           = 1'b0;
        drive(0, 0, 20);

        // Clean set, then release
        drive(1, 0, 15);
        drive(0, 0, 15);

        // Bounce: 3-cycle glitch then a steady level
        drive(1, 0, 3);
        drive(0, 0, 1);
        drive(1, 0, 15);
        drive(0, 0, 15);

        // Simultaneous requests
        drive(1, 1, 15);
        drive(0, 0, 15);

        // Set event arriving during the hold-off after a reset pulse
        drive(0, 1, 2);
        drive(1, 1, 15);
        drive(0, 0, 15);

        // Reset while a set request is pending in hold-off
        drive(0, 1, 2);
        drive(1, 1, 7);
        assert_rst_and_check();
        bus.set_raw   = 1'b0;
        bus.reset_raw = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        drive(0, 0, 20);

        // Raw set held high across reset release still yields one pulse
        drive(1, 0, 3);
        assert_rst_and_check();
        repeat (3) step();
        rst = 1'b0;
        drive(1, 0, 15);
        drive(0, 0, 10);

        // Random bouncing traffic with occasional resets
        len_s = 0;
        len_r = 0;
        vs    = 1'b0;
        vr    = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (len_s == 0) begin
                vs    = 1'($urandom_range(0, 1));
                len_s = $urandom_range(1, 12);
            end
            if (len_r == 0) begin
                vr    = 1'($urandom_range(0, 1));
                len_r = $urandom_range(1, 12);
            end
            len_s = len_s - 1;
            len_r = len_r - 1;
            bus.set_raw   = vs;
            bus.reset_raw = vr;
            if ($urandom_range(0, 599) == 0) begin
                assert_rst_and_check();
                repeat (2) step();
                rst = 1'b0;
            end
            step();
        end

        drive(0, 0, 30);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
